// File: rtl/rr_arbiter_4_pkg.sv
// Shared constants for the four-client round-robin arbiter.
// Also provides the one-hot helper used for masking the current holder.
package rr_arbiter_4_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam int unsigned NUM_CLIENTS  = 4;
  localparam int unsigned IDX_W        = 2;
  localparam int unsigned MAX_HOLD_DEF = 8;

  function automatic logic [NUM_CLIENTS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    idx_onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_decoder.sv
// 2-to-4 decoder with enable: turns the registered winner index into the
// one-hot grant vector, forcing all zeros when no grant is active.
module decoder_2x4_en (
  input  logic [1:0] a,
  input  logic       enable,
  output logic [3:0] y
);

  // Gated index decode
  always_comb begin
    y = 4'b0000;
    if (enable) begin
      case (a)
        2'd0:    y = 4'b0001;
        2'd1:    y = 4'b0010;
        2'd2:    y = 4'b0100;
        2'd3:    y = 4'b1000;
        default: y = 4'b0000;
      endcase
    end else begin
      y = 4'b0000;
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter; grants are held until the winner releases.
// Define ARB_TIMEOUT_EN to force rotation after MAX_HOLD cycles of contention.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_CLIENTS-1:0] req,
  output logic [NUM_CLIENTS-1:0] gnt,
  output logic [IDX_W-1:0]       gnt_idx,
`ifdef ARB_TIMEOUT_EN
  output logic                   timeout,
`endif
  output logic                   gnt_valid
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_4: MAX_HOLD must lie in 2..255");
  end

  // First requester at or after p, wrapping modulo 4; the reverse loop lets the
  // smallest offset overwrite larger ones.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] r,
                                               input logic [IDX_W-1:0]       p);
    logic [IDX_W-1:0] cand;
    rr_pick = p;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      cand = p + i[IDX_W-1:0];
      if (r[cand]) begin
        rr_pick = cand;
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] next_ptr_s;

  assign next_ptr_s = idx_q + 2'd1;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0]             hold_q, hold_d;
  logic                   timeout_q, timeout_d;
  logic [NUM_CLIENTS-1:0] others_s;

  assign others_s = req & ~idx_onehot(idx_q);
`endif

  // Next-state, winner and pointer selection
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    if (!enable) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_d  = 8'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req != 4'b0000) begin
            idx_d   = rr_pick(req, ptr_q);
            state_d = ST_GRANT;
            valid_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          hold_d = 8'd0;
`endif
        end
        ST_GRANT: begin
          if (!req[idx_q]) begin
            // Holder released: advance the pointer and re-arbitrate in the same edge
            ptr_d = next_ptr_s;
            if (req != 4'b0000) begin
              idx_d = rr_pick(req, next_ptr_s);
            end else begin
              state_d = ST_IDLE;
              valid_d = 1'b0;
            end
`ifdef ARB_TIMEOUT_EN
            hold_d = 8'd0;
          end else if (hold_q == HOLD_LAST && others_s != 4'b0000) begin
            timeout_d = 1'b1;
            ptr_d     = next_ptr_s;
            idx_d     = rr_pick(req, next_ptr_s);
            hold_d    = 8'd0;
          end else if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + 8'd1;
          end else begin
            hold_d = hold_q;
`endif
          end else begin
            idx_d = idx_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      ptr_q   <= 2'd0;
      valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  decoder_2x4_en u_dec (
    .a      (idx_q),
    .enable (valid_q),
    .y      (gnt)
  );

  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: the driver queues the expected outputs
// after each edge, and a monitor pops and compares them one step later.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout_s;

  logic [7:0] exp_q[$];
  string      name_q[$];
  int         n_checks;
  int         n_pass;

  rr_arbiter_4 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
`ifdef ARB_TIMEOUT_EN
    .timeout   (timeout_s),
`endif
    .gnt_valid (gnt_valid)
  );

`ifndef ARB_TIMEOUT_EN
  assign timeout_s = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs on the falling edge; queue what must be seen after the next rising edge
  task automatic step(input string nm, input logic r, input logic en, input logic [3:0] rq,
                      input logic [3:0] eg, input logic [1:0] ei, input logic ev,
                      input logic et);
    @(negedge clk);
    rst    = r;
    enable = en;
    req    = rq;
    exp_q.push_back({et, ev, ei, eg});
    name_q.push_back(nm);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation
  initial begin
    logic [7:0] e;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if ({timeout_s, gnt_valid, gnt_idx, gnt} === e) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b, need gnt=%b idx=%0d valid=%b timeout=%b",
                   nm, gnt, gnt_idx, gnt_valid, timeout_s, e[3:0], e[5:4], e[6], e[7]);
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    enable   = 1'b0;
    req      = 4'b0000;

    step("reset0", 1'b1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("reset1", 1'b1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single request, then release to IDLE (ptr becomes 3)
    step("single_gnt", 1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("single_rel", 1'b0, 1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    step("idle_stay",  1'b0, 1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

    // Full contention from ptr=0: order 0,1,2,3,0 with no bubble
    step("rst_pre_rot", 1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      step("rot_c0", 1'b0, 1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("rot_c1", 1'b0, 1'b1, 4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++)
      step("rot_c1_hold", 1'b0, 1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("rot_c2", 1'b0, 1'b1, 4'b1101, 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++)
      step("rot_c2_hold", 1'b0, 1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rot_c3", 1'b0, 1'b1, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++)
      step("rot_c3_hold", 1'b0, 1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("rot_c0_again", 1'b0, 1'b1, 4'b0111, 4'b0001, 2'd0, 1'b1, 1'b0);

    // Wrap-around: release client 0 (ptr=1), grant 3, release 3 -> search from 0
    step("wrap_idle", 1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("wrap_g3",   1'b0, 1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("wrap_hold", 1'b0, 1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("wrap_to0",  1'b0, 1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);

    // Enable revoke during grant to client 1 (ptr=1 kept across the disable)
    step("en_g1", 1'b0, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      step("en_off", 1'b0, 1'b0, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0);
    step("en_resume", 1'b0, 1'b1, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);

    // Reset while client 3 holds the grant
    step("mid_g3",    1'b0, 1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("mid_rst",   1'b1, 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("post_rst",  1'b0, 1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("dis_idle",  1'b0, 1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Forced rotation with MAX_HOLD=4 under constant contention
    step("to_rst", 1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++)
        step("to_c0", 1'b0, 1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1, (r > 0 && k == 0));
      for (int k = 0; k < 4; k++)
        step("to_c1", 1'b0, 1'b1, 4'b0011, 4'b0010, 2'd1, 1'b1, (k == 0));
    end
    // Sole requester never times out
    step("solo_rst", 1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++)
      step("solo_c0", 1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
`endif

    // Let the monitor drain, bounded
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that shares one resource among four clients.
- The 2-bit winning index is held in a register and drives a 2-to-4 enable-gated decoder, which produces the one-hot grant vector.
- Sits between four client request lines and the shared resource select. Grants are held until the winner releases its request.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one client may hold the grant while others wait. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..255.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  global arbiter enable. 0 means no new grants and the current grant is revoked.
- req  input  4  request per client; bit i is client i.
- gnt  output  4  one-hot grant from the internal decoder. All zero when nothing is granted.
- gnt_idx  output  2  registered index of the current or last winner.
- gnt_valid  output  1  1 while any grant is active; equals OR of gnt.
- timeout  output  1  one-cycle pulse on forced rotation. Present only with ARB_TIMEOUT_EN.

Behaviour:
- One clock: clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state=IDLE, gnt=0000, gnt_idx=00, gnt_valid=0, ptr=00.
  - hold counter=0; timeout=0.
  - Reset asserted mid-grant drops gnt on the next edge.
- ptr is the first client to check. Search order is ptr, ptr+1, ptr+2, ptr+3, mod 4, with 2-bit wrap (3+1 -> 0).
- IDLE:
  - If enable=1 and req!=0, latch the first requester in search order into gnt_idx and go to GRANT.
  - gnt is asserted the cycle after req is first sampled (latency 1).
- GRANT:
  - gnt = decode(gnt_idx) while req[gnt_idx]=1 and enable=1.
  - Release (req[gnt_idx]=0 at an edge): set ptr=gnt_idx+1 and search again in the same edge.
  - If another request is pending, go straight to the new winner with no idle bubble. Otherwise go to IDLE with gnt=0000.
  - Requests from other clients during GRANT never preempt the holder, except through the optional timeout.
- enable=0 in any state:
  - Next state is IDLE and gnt=0000.
  - ptr and gnt_idx are kept.
  - Re-enabling resumes the search from the kept ptr.
- A client that drops and re-raises req in consecutive cycles loses priority to other pending clients through the ptr advance.
- Simultaneous requests resolve strictly by search order from ptr. After reset, ptr=0, so req=1111 grants client 0 first.
- gnt is always one-hot or zero; it never has two bits set.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter counts GRANT cycles for the current holder and clears on every new grant or on IDLE.
  - Forced rotation happens when the counter reaches MAX_HOLD-1 while req[gnt_idx]=1 and some other req bit is set.
  - On forced rotation: pulse timeout for one cycle, set ptr=gnt_idx+1, and hand the grant to the next pending requester at that edge.
  - If the holder is the only requester, no timeout occurs and the counter saturates.
- Not defined:
  - No counter and no timeout port.
  - The holder keeps the grant indefinitely.

Decomposition:
- Shared package:
  - State encoding constants ST_IDLE=0 and ST_GRANT=1.
  - Client count constant 4.
  - Index width constant 2.
  - Default MAX_HOLD.
- Sub-module: decoder_2x4_en. A combinational 2-to-4 decoder with enable.
  - Inputs: a[1:0], enable.
  - Output: y[3:0].
  - Instanced once, with a=gnt_idx and enable=gnt_valid_reg.
- The priority search is a combinational function in the top module, not a separate module.

Test Plan:
- Reset then single request:
  - Stimulus: rst=1 for 2 cycles, then enable=1, req=0100.
  - Required: gnt=0100 and gnt_idx=10 one cycle later. req=0000 -> gnt=0000 next cycle, IDLE.
- Full contention rotation:
  - Stimulus: req=1111 held; each holder drops its bit for one cycle after a 3-cycle hold.
  - Required: grant order is clients 0,1,2,3,0. No bubble between grants. gnt is never multi-hot.
- Wrap-around:
  - Stimulus: grant client 3 with req=1001, then release bit 3.
  - Required: grant moves to client 0 (gnt=0001) and ptr wraps to 00.
- Enable revoke:
  - Stimulus: during a grant to client 1, enable=0 for 3 cycles, then enable=1 with req=0011.
  - Required: gnt=0000 while disabled. After re-enable, the search starts at the kept ptr.
- Reset mid-grant:
  - Stimulus: rst=1 while gnt=1000.
  - Required: all outputs zero next edge. With req=1111 after reset, client 0 wins.
- ARB_TIMEOUT_EN defined, MAX_HOLD=4:
  - Stimulus: req=0011 held constant.
  - Required: client 0 for 4 cycles, timeout pulse, then client 1 for 4 cycles, repeating.
  - With req=0001 only: no timeout pulse ever.
